// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled async serial receiver feeding a show-ahead receive FIFO with sticky error flags
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_AW    = 4
) (
   input  logic             rxclk,
   input  logic             reset,
   input  logic             rx_enable,
   input  logic             rx_in,
   input  logic             rd_en,
   output logic [7:0]       rx_data,
   output logic             rx_empty,
   output logic             rx_full,
   output logic [FIFO_AW:0] rx_count,
   output logic             frame_err,
   output logic             parity_err,
   output logic             over_run,
   input  logic             err_clr
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
   localparam logic [2:0] B_LAST = 3'(DATA_BITS - 1);
   localparam logic S_LAST = 1'(STOP_BITS - 1);
   localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(2 ** FIFO_AW);
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
   state_t state;
   logic s1, s2, par_bad, stop_bad, stop_idx;
   logic [TW-1:0] tick;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic [7:0] mem [2**FIFO_AW];
   logic [FIFO_AW:0] wr_ptr, rd_ptr;
   logic mid, last_stop, frame_bad, push, pop, wr, exp_par;
   assign mid       = tick == T_END;
   assign last_stop = rx_enable && state == STOP && mid && stop_idx == S_LAST;
   assign frame_bad = stop_bad | ~s2;
   assign push      = last_stop & ~frame_bad;
   assign pop       = rd_en & ~rx_empty;
   // full is judged after a same-cycle pop, so push+pop on a full FIFO is legal
   assign wr        = push & (~rx_full | pop);
   assign exp_par   = (PARITY == 2) ? ^shreg : ~^shreg;
   assign rx_count  = wr_ptr - rd_ptr;
   assign rx_empty  = wr_ptr == rd_ptr;
   assign rx_full   = rx_count == DEPTH;
   assign rx_data   = rx_empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];
   always_ff @(posedge rxclk or posedge reset)
      if (reset) begin
         s1       <= 1'b1;
         s2       <= 1'b1;
         state    <= IDLE;
         tick     <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par_bad  <= 1'b0;
         stop_bad <= 1'b0;
      end else begin
         s1   <= rx_in;
         s2   <= s1;
         tick <= (state == IDLE || (state == START && tick == T_MID) || mid) ? '0 : tick + 1'b1;
         if (!rx_enable) state <= IDLE;
         else case (state)
            IDLE: if (!s2) begin
               state    <= START;
               shreg    <= '0;
               bit_idx  <= '0;
               stop_idx <= 1'b0;
               par_bad  <= 1'b0;
               stop_bad <= 1'b0;
            end
            START: if (tick == T_MID) state <= s2 ? IDLE : DATA;
            DATA: if (mid) begin
               shreg[bit_idx] <= s2;
               bit_idx        <= bit_idx + 1'b1;
               if (bit_idx == B_LAST) state <= (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (mid) begin
               par_bad <= s2 != exp_par;
               state   <= STOP;
            end
            STOP: if (mid) begin
               stop_bad <= frame_bad;
               stop_idx <= stop_idx + 1'b1;
               if (stop_idx == S_LAST) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   always_ff @(posedge rxclk or posedge reset)
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         over_run   <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr + (FIFO_AW + 1)'(wr);
         rd_ptr     <= rd_ptr + (FIFO_AW + 1)'(pop);
         frame_err  <= (last_stop & frame_bad) | (frame_err & ~err_clr);
         parity_err <= (push & par_bad) | (parity_err & ~err_clr);
         over_run   <= (push & ~wr) | (over_run & ~err_clr);
      end
   always_ff @(posedge rxclk)
      if (wr) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
endmodule
